dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-RAM port between the CPU MEM stage (requester 0) and a DMA/debug loader (requester 1). The CPU has default priority. The DMA is protected by a starvation counter and may hold a locked burst, bounded by a forced yield slot. RAM reads are synchronous, one-cycle latency. The block drives a stall into the CPU pipeline whenever the CPU is denied.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA slot (>=1)
BURST_MAX, 8, maximum consecutive locked DMA grants before a forced CPU yield (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access performed this cycle
cpu_stall  out  1  cpu_req && !cpu_gnt
cpu_rvalid  out  1  read data valid for CPU
dma_req  in  1  DMA request
dma_we  in  1  1=write
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_lock  in  1  request bus lock (burst)
dma_gnt  out  1  DMA access performed this cycle
dma_rvalid  out  1  read data valid for DMA
rdata  out  DATA_W  ram_rdata passthrough, shared by both requesters
ram_addr  out  ADDR_W  muxed address, 0 when idle
ram_wdata  out  DATA_W  muxed write data, 0 when idle
ram_we  out  1  write strobe
ram_re  out  1  read strobe
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_re

Behaviour:
- Grants are combinational from registered state and current requests. At most one grant per cycle. A requester holds req and operands stable until it sees gnt; the transfer completes in the gnt cycle.
- States: IDLE, LOCKED, YIELD.
- IDLE:
  - dma_gnt = dma_req && (!cpu_req || wait_cnt==MAX_WAIT).
  - cpu_gnt = cpu_req && !dma_gnt.
  - dma_gnt && dma_lock -> LOCKED, burst_cnt=1.
- LOCKED:
  - dma_gnt = dma_req; cpu_gnt = 0.
  - On each dma_gnt, burst_cnt is incremented.
  - Exit to IDLE: dma_req=0, or dma_gnt with dma_lock=0.
  - Exit to YIELD: dma_gnt when burst_cnt==BURST_MAX.
- YIELD (one cycle):
  - cpu_gnt = cpu_req; dma_gnt = dma_req && !cpu_req.
  - Next state is IDLE; burst_cnt cleared. The lock is not resumed; the DMA must re-assert dma_lock.
- wait_cnt: increments when dma_req && !dma_gnt, saturating at MAX_WAIT. Cleared on dma_gnt or dma_req=0.
- RAM mux: ram_* is driven from the granted requester. ram_we=gnt&we, ram_re=gnt&!we. All ram_* outputs are 0 with no grant.
- cpu_rvalid <= cpu_gnt & !cpu_we; dma_rvalid <= dma_gnt & !dma_we (registered, one-cycle latency).
- Reset: state IDLE, wait_cnt=0, burst_cnt=0, rvalids=0. The gnt, stall and ram_* outputs follow the combinational rules with state=IDLE. Reset mid-LOCKED drops the lock and any pending rvalid.
- Both requesting with wait_cnt<MAX_WAIT: CPU wins.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds outputs perf_cpu_stall [31:0], counting cycles with cpu_stall=1, and perf_dma_xfers [31:0], counting dma_gnt cycles. Both clear on reset and wrap modulo 2^32.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds the state encodings ST_IDLE=2'd0, ST_LOCKED=2'd1, ST_YIELD=2'd2, and requester indices REQ_CPU=0, REQ_DMA=1.
- One sub-module, arb_sat_counter (width/max parameters; inc, clr inputs; count and at_max outputs), instanced for wait_cnt and burst_cnt.

Test Plan:
- CPU read 0x10 alone -> cpu_gnt=1, ram_re=1, ram_addr=0x10 same cycle; cpu_rvalid=1 next cycle with rdata=RAM[0x10].
- cpu_req and dma_req held continuously, MAX_WAIT=4 -> CPU granted cycles 0-3; dma_gnt=1 and cpu_stall=1 in cycle 4; wait_cnt back to 0.
- DMA locked burst of 12 writes, CPU requesting, BURST_MAX=8 -> 8 dma_gnt, one YIELD cycle with cpu_gnt=1, then DMA re-arbitrates from IDLE.
- DMA lock with dma_lock dropped on its 3rd grant -> returns to IDLE after 3 transfers; CPU granted next cycle.
- Reset asserted during LOCKED with a DMA read granted -> next cycle state IDLE, dma_rvalid=0, cpu_req granted immediately.
- ARB_PERF_CNT_EN defined, 5 CPU stall cycles and 3 DMA transfers -> perf_cpu_stall=5, perf_dma_xfers=3.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-RAM port arbiter: FSM states, requester indices
// and the counter width helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_YIELD  = 2'd2
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;
  localparam int NUM_REQ = 2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count_q == WIDTH'(MAX));
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-RAM port between the CPU MEM stage and a DMA/debug
// loader. Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cpu_stall,
  output logic [31:0]       perf_dma_xfers
`endif
);

  localparam int WAIT_W  = cnt_width(MAX_WAIT);
  localparam int BURST_W = cnt_width(BURST_MAX - 1);

  arb_state_e         state_q, state_d, state_cur;
  logic [NUM_REQ-1:0] gnt;
  logic [WAIT_W-1:0]  wait_count;
  logic [BURST_W-1:0] burst_count;
  logic               wait_at_max;
  logic               burst_last;
  logic               cpu_rvalid_q, dma_rvalid_q;
  logic               unused_cnt;

  // While reset is held the grant logic already behaves as IDLE.
  assign state_cur = reset ? ST_IDLE : state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_cur;
    case (state_cur)
      ST_IDLE: begin
        if (gnt[REQ_DMA] && dma_lock) begin
          state_d = (BURST_MAX == 1) ? ST_YIELD : ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!dma_req || !dma_lock) begin
          state_d = ST_IDLE;
        end else if (burst_last) begin
          state_d = ST_YIELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state_cur)
      ST_IDLE: begin
        gnt[REQ_DMA] = dma_req && (!cpu_req || wait_at_max);
        gnt[REQ_CPU] = cpu_req && !gnt[REQ_DMA];
      end
      ST_LOCKED: gnt[REQ_DMA] = dma_req;
      ST_YIELD: begin
        gnt[REQ_CPU] = cpu_req;
        gnt[REQ_DMA] = dma_req && !cpu_req;
      end
      default: gnt = '0;
    endcase
    if (gnt[REQ_CPU]) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      ram_re    = !cpu_we;
    end else if (gnt[REQ_DMA]) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
      ram_re    = !dma_we;
    end
  end

  assign cpu_gnt   = gnt[REQ_CPU];
  assign dma_gnt   = gnt[REQ_DMA];
  assign cpu_stall = cpu_req && !gnt[REQ_CPU];
  assign rdata     = ram_rdata;

  arb_sat_counter #(.MAX(MAX_WAIT), .WIDTH(WAIT_W)) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (dma_req && !gnt[REQ_DMA]),
    .clr    (gnt[REQ_DMA] || !dma_req),
    .count  (wait_count),
    .at_max (wait_at_max)
  );

  // Counts locked grants; saturation marks the grant after which the CPU must get a slot.
  arb_sat_counter #(.MAX(BURST_MAX - 1), .WIDTH(BURST_W)) u_burst_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (gnt[REQ_DMA] && (state_d == ST_LOCKED)),
    .clr    (state_d != ST_LOCKED),
    .count  (burst_count),
    .at_max (burst_last)
  );

  assign unused_cnt = ^{wait_count, burst_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= gnt[REQ_CPU] && !cpu_we;
      dma_rvalid_q <= gnt[REQ_DMA] && !dma_we;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_xfer_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_xfer_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + {31'd0, cpu_stall};
      perf_xfer_q  <= perf_xfer_q + {31'd0, gnt[REQ_DMA]};
    end
  end

  assign perf_cpu_stall = perf_stall_q;
  assign perf_dma_xfers = perf_xfer_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_cpu_stall, perf_dma_xfers;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_lock   (dma_lock),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_cpu_stall (perf_cpu_stall),
    .perf_dma_xfers (perf_dma_xfers)
`endif
  );

  // Behavioural RAM with one-cycle read latency.
  logic [31:0] mem [0:255];
  logic [31:0] exp_mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic [63:0] tag;
    logic        cg, dg, stall, we, re, crv, drv;
    logic [31:0] addr, wdata, rdat, pstall, pxfer;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        pend_c = 1'b0, pend_d = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] cnt_stall = '0, cnt_xfer = '0;

  task automatic chk(input logic [63:0] tag, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %0s %0s: got %h expected %h", tag, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.tag, "cpu_gnt", {31'd0, cpu_gnt}, {31'd0, mon_e.cg});
      chk(mon_e.tag, "dma_gnt", {31'd0, dma_gnt}, {31'd0, mon_e.dg});
      chk(mon_e.tag, "cpu_stall", {31'd0, cpu_stall}, {31'd0, mon_e.stall});
      chk(mon_e.tag, "ram_we", {31'd0, ram_we}, {31'd0, mon_e.we});
      chk(mon_e.tag, "ram_re", {31'd0, ram_re}, {31'd0, mon_e.re});
      chk(mon_e.tag, "ram_addr", ram_addr, mon_e.addr);
      chk(mon_e.tag, "ram_wdata", ram_wdata, mon_e.wdata);
      chk(mon_e.tag, "cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, mon_e.crv});
      chk(mon_e.tag, "dma_rvalid", {31'd0, dma_rvalid}, {31'd0, mon_e.drv});
      if (mon_e.crv || mon_e.drv) chk(mon_e.tag, "rdata", rdata, mon_e.rdat);
`ifdef ARB_PERF_CNT_EN
      chk(mon_e.tag, "perf_cpu_stall", perf_cpu_stall, mon_e.pstall);
      chk(mon_e.tag, "perf_dma_xfers", perf_dma_xfers, mon_e.pxfer);
`endif
      $display("%0t %0s gnt c/d=%0b/%0b addr=%h rv c/d=%0b/%0b rdata=%h", $time, mon_e.tag,
               cpu_gnt, dma_gnt, ram_addr, cpu_rvalid, dma_rvalid, rdata);
    end
  end

  // One cycle of stimulus; the caller supplies the hand-derived grant outcome.
  task automatic step(input logic [63:0] tag, input logic rst,
                      input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd,
                      input logic dl, input logic xcg, input logic xdg);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    cpu_req   = cr;  cpu_we = cw;  cpu_addr = {24'd0, ca};  cpu_wdata = cd;
    dma_req   = dr;  dma_we = dw;  dma_addr = {24'd0, da};  dma_wdata = dd;
    dma_lock  = dl;
    e.tag     = tag;
    e.cg      = xcg;
    e.dg      = xdg;
    e.stall   = cr && !xcg;
    e.we      = xcg ? cw : (xdg ? dw : 1'b0);
    e.re      = xcg ? !cw : (xdg ? !dw : 1'b0);
    e.addr    = xcg ? {24'd0, ca} : (xdg ? {24'd0, da} : 32'd0);
    e.wdata   = xcg ? cd : (xdg ? dd : 32'd0);
    e.crv     = pend_c;
    e.drv     = pend_d;
    e.rdat    = pend_data;
    e.pstall  = cnt_stall;
    e.pxfer   = cnt_xfer;
    exp_q.push_back(e);
    pend_c = !rst && xcg && !cw;
    pend_d = !rst && xdg && !dw;
    if (xcg && !cw) pend_data = exp_mem[ca];
    if (xdg && !dw) pend_data = exp_mem[da];
    if (xcg && cw) exp_mem[ca] = cd;
    if (xdg && dw) exp_mem[da] = dd;
    if (rst) begin
      cnt_stall = '0;
      cnt_xfer  = '0;
    end else begin
      if (cr && !xcg) cnt_stall = cnt_stall + 1;
      if (xdg) cnt_xfer = cnt_xfer + 1;
    end
  endtask

  task automatic idle(input logic [63:0] tag);
    step(tag, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hD000_0000 + i;
      exp_mem[i] = 32'hD000_0000 + i;
    end
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;

    repeat (2) step("reset", 1'b1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);

    // Lone CPU read, then write/read-back.
    step("cpu_rd", 0, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    step("cpu_wr", 0, 1, 1, 8'h20, 32'hCAFE_0020, 0, 0, 8'h00, 0, 0, 1, 0);
    step("cpu_rb", 0, 1, 0, 8'h20, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    idle("idle");

    // Contention: CPU wins four cycles, DMA forced in on the fifth, wait count restarts.
    for (int i = 0; i < 4; i++)
      step("contend", 0, 1, 0, 8'h30 + 8'(i), 0, 1, 1, 8'h80, 32'h1111_0000, 0, 1, 0);
    step("forced", 0, 1, 0, 8'h34, 0, 1, 1, 8'h80, 32'h1111_0000, 0, 0, 1);
    step("waitclr", 0, 1, 0, 8'h34, 0, 1, 1, 8'h81, 32'h1111_0001, 0, 1, 0);
    step("dmaonly", 0, 0, 0, 8'h00, 0, 1, 1, 8'h81, 32'h1111_0001, 0, 0, 1);
    idle("idle");

    // Locked burst of 12 writes against a waiting CPU: 8 grants, yield, re-arbitrate.
    step("burst", 0, 0, 0, 8'h00, 0, 1, 1, 8'h90, 32'hB000_0000, 1, 0, 1);
    for (int k = 1; k < 8; k++)
      step("burst", 0, 1, 0, 8'h40, 0, 1, 1, 8'h90 + 8'(k), 32'hB000_0000 + k, 1, 0, 1);
    step("yield", 0, 1, 0, 8'h40, 0, 1, 1, 8'h98, 32'hB000_0008, 1, 1, 0);
    step("rearb", 0, 1, 0, 8'h41, 0, 1, 1, 8'h98, 32'hB000_0008, 1, 1, 0);
    for (int j = 0; j < 4; j++)
      step("burst2", 0, 0, 0, 8'h00, 0, 1, 1, 8'h98 + 8'(j), 32'hB000_0008 + j, (j != 3), 0, 1);
    step("unlock", 0, 1, 0, 8'h42, 0, 1, 1, 8'hA0, 32'hA0A0_A0A0, 1, 1, 0);
    idle("idle");

    // Lock dropped on the third grant; CPU must win straight after.
    step("lk3", 0, 0, 0, 8'h00, 0, 1, 0, 8'h90, 0, 1, 0, 1);
    step("lk3", 0, 1, 0, 8'h11, 0, 1, 0, 8'h91, 0, 1, 0, 1);
    step("lk3", 0, 1, 0, 8'h11, 0, 1, 0, 8'h92, 0, 0, 0, 1);
    step("lk3cpu", 0, 1, 0, 8'h11, 0, 1, 0, 8'h93, 0, 1, 1, 0);
    idle("idle");

    // Reset while locked with a DMA read in flight.
    step("rstlk", 0, 0, 0, 8'h00, 0, 1, 0, 8'h93, 0, 1, 0, 1);
    step("rstlk", 1, 0, 0, 8'h00, 0, 1, 0, 8'h94, 0, 1, 0, 1);
    step("postrst", 0, 1, 0, 8'h12, 0, 1, 0, 8'h95, 0, 1, 1, 0);
    idle("idle");
    idle("idle");

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
